// File: rtl/uart_receiver.sv
// 16x-oversampling UART receiver: 1 start, 8 data bits MSB-first, optional even parity, 1 stop.
// Define UART_RX_PARITY_EN to add the parity bit after the data bits.
module uart_receiver #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int OS_RATE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxEn,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       rxValid,
    output logic       rxBusy,
    output logic       rxFrameErr,
    output logic       rxParityErr
);

    localparam int DIV   = CLK_FREQ / (BAUD * OS_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_check
        $error("uart_receiver: CLK_FREQ/(BAUD*OS_RATE) must be >= 1");
    end
    if (OS_RATE != 16) begin : g_os_check
        $error("uart_receiver: OS_RATE must be 16");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_s_q;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [3:0]         samp_cnt_q, samp_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic               parity_err_q, parity_err_d;
    logic               os_tick;
    logic               parity_ok;
`ifdef UART_RX_PARITY_EN
    logic               parity_q, parity_d;
    assign parity_ok = ~^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    assign os_tick = (div_cnt_q == DIV_W'(DIV - 1));

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = os_tick ? '0 : div_cnt_q + DIV_W'(1);
        samp_cnt_d   = samp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        out_data_d   = out_data_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d     = parity_q;
`endif
        if (!rxEn) begin
            state_d    = S_IDLE;
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = S_START;
                        div_cnt_d  = '0;
                        samp_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                S_START: begin
                    if (os_tick) begin
                        if (samp_cnt_q == 4'd7) begin
                            samp_cnt_d = '0;
                            state_d    = rx_s_q ? S_IDLE : S_DATA;
                        end else begin
                            samp_cnt_d = samp_cnt_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (os_tick) begin
                        if (samp_cnt_q == 4'd15) begin
                            samp_cnt_d = '0;
                            shift_d    = {shift_q[6:0], rx_s_q};
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                                state_d   = S_PARITY;
`else
                                state_d   = S_STOP;
`endif
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end else begin
                            samp_cnt_d = samp_cnt_q + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (os_tick) begin
                        if (samp_cnt_q == 4'd15) begin
                            samp_cnt_d = '0;
                            parity_d   = rx_s_q;
                            state_d    = S_STOP;
                        end else begin
                            samp_cnt_d = samp_cnt_q + 4'd1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (os_tick) begin
                        if (samp_cnt_q == 4'd15) begin
                            samp_cnt_d = '0;
                            if (rx_s_q) begin
                                state_d = S_IDLE;
                                if (parity_ok) begin
                                    out_data_d = shift_q;
                                    valid_d    = 1'b1;
                                end else begin
                                    parity_err_d = 1'b1;
                                end
                            end else begin
                                // A low stop bit outranks any parity verdict.
                                frame_err_d = 1'b1;
                                state_d     = S_BREAK;
                            end
                        end else begin
                            samp_cnt_d = samp_cnt_q + 4'd1;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            div_cnt_q    <= '0;
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            out_data_q   <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            div_cnt_q    <= div_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign out_data    = out_data_q;
    assign rxValid     = valid_q;
    assign rxBusy      = (state_q != S_IDLE);
    assign rxFrameErr  = frame_err_q;
    assign rxParityErr = parity_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at DIV=2 (32 clk per bit): vector table plus
// hand-written corner sequences, all pulses checked against a scoreboard queue.
module tb_uart_receiver;

    localparam int BIT = 32;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_FERR  = 2;
    localparam int K_PERR  = 3;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       bad_par;
        int         kind;
    } vec_t;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxEn;
    logic       rx;
    logic [7:0] out_data;
    logic       rxValid, rxBusy, rxFrameErr, rxParityErr;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   valid_times[$];
    logic [7:0] last_good = 8'h00;
    vec_t vecs[$];

    logic prev_pulse = 1'b0;
    int   got_kind;
    exp_t got_exp;

    uart_receiver #(
        .CLK_FREQ(3200000),
        .BAUD    (100000),
        .OS_RATE (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxEn       (rxEn),
        .rx         (rx),
        .out_data   (out_data),
        .rxValid    (rxValid),
        .rxBusy     (rxBusy),
        .rxFrameErr (rxFrameErr),
        .rxParityErr(rxParityErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every output pulse is matched against the front of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_pulse = 1'b0;
        end else begin
            got_kind = rxValid ? K_VALID : rxFrameErr ? K_FERR : rxParityErr ? K_PERR : K_NONE;
            if (got_kind != K_NONE) begin
                check("pulse_onehot", 32'($countones({rxValid, rxFrameErr, rxParityErr})), 32'd1);
                check("pulse_width", 32'(prev_pulse), 32'd0);
                if (rxValid) valid_times.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'(got_kind), 32'(K_NONE));
                end else begin
                    got_exp = sb.pop_front();
                    check("pulse_kind", 32'(got_kind), 32'(got_exp.kind));
                    check("out_data", 32'(out_data), 32'(got_exp.data));
                end
            end
            prev_pulse = (got_kind != K_NONE);
        end
    end

    task automatic expect_pulse(input int kind, input logic [7:0] d);
        exp_t e;
        if (kind == K_VALID) last_good = d;
        e.kind = kind;
        e.data = last_good;
        sb.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par,
                              input logic release_line);
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ bad_par);
`endif
        drive_bit(stop);
        if (release_line) rx = 1'b1;
    endtask

    task automatic settle_and_check(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        check({tag, "_busy_idle"}, 32'(rxBusy), 32'd0);
    endtask

    initial begin
        vecs.push_back('{8'hA5, 1'b1, 1'b0, K_VALID});
        vecs.push_back('{8'h00, 1'b1, 1'b0, K_VALID});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, K_VALID});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, K_FERR});
        vecs.push_back('{8'h96, 1'b1, 1'b0, K_VALID});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, K_VALID});
        vecs.push_back('{8'h07, 1'b1, 1'b1, K_PERR});
        vecs.push_back('{8'h18, 1'b0, 1'b1, K_FERR});
`endif

        // Reset state
        rst  = 1'b1;
        rxEn = 1'b1;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_valid", 32'(rxValid), 32'd0);
        check("rst_busy", 32'(rxBusy), 32'd0);
        check("rst_ferr", 32'(rxFrameErr), 32'd0);
        check("rst_perr", 32'(rxParityErr), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven frames
        foreach (vecs[i]) begin
            expect_pulse(vecs[i].kind, vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].bad_par, 1'b1);
            settle_and_check("vec");
        end

        // Back-to-back frames, one stop bit each
        valid_times.delete();
        expect_pulse(K_VALID, 8'h00);
        expect_pulse(K_VALID, 8'hFF);
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        settle_and_check("b2b");
        check("b2b_count", 32'(valid_times.size()), 32'd2);
        if (valid_times.size() == 2)
            check("b2b_spacing", 32'(valid_times[1] - valid_times[0]), 32'(FRAME_BITS * BIT));

        // Short low glitch: false start, no pulse
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_seen", 32'(rxBusy), 32'd1);
        repeat (16) @(negedge clk);
        check("glitch_busy_clear", 32'(rxBusy), 32'd0);
        settle_and_check("glitch");

        // Low stop bit, line held low: BREAK until line recovers
        expect_pulse(K_FERR, 8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("brk_sb_drained", 32'(sb.size()), 32'd0);
        check("brk_busy_held", 32'(rxBusy), 32'd1);
        check("brk_data_kept", 32'(out_data), 32'(last_good));
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("brk_busy_clear", 32'(rxBusy), 32'd0);
        expect_pulse(K_VALID, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        settle_and_check("post_brk");

        // Async reset mid-data of 0x81
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_busy", 32'(rxBusy), 32'd0);
        check("midrst_valid", 32'(rxValid), 32'd0);
        last_good = 8'h00;
        @(negedge clk);
        rx  = 1'b1;
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        expect_pulse(K_VALID, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        settle_and_check("post_rst");

        // rxEn dropped mid-frame: abort next clock, nothing delivered
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rxEn = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(rxBusy), 32'd0);
        for (int i = 5; i >= 0; i--) drive_bit(i[0]);
        drive_bit(1'b1);
        rxEn = 1'b1;
        repeat (BIT) @(negedge clk);
        check("abort_data_kept", 32'(out_data), 32'(last_good));
        settle_and_check("abort");
        expect_pulse(K_VALID, 8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        settle_and_check("post_abort");

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
